// File: rtl/packet_unpacker_pkg.sv
// Shared types and constants for the receive-side packet unpacker.
// Word indices follow the on-air field order of the reward packer.
package packet_unpacker_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int PKT_WORDS  = 8;
    localparam logic [WORD_WIDTH-1:0] BCAST_ID = 16'hFFFF;

    localparam int W_HEADER      = 0;
    localparam int W_SOURCE      = 1;
    localparam int W_DESTINATION = 2;
    localparam int W_ENERGY      = 3;
    localparam int W_QVALUE      = 4;
    localparam int W_SRC_HOPS    = 5;
    localparam int W_CHOSEN_CH   = 6;
    localparam int W_HOPS_CH     = 7;

    typedef enum logic [2:0] {
        PKT_HB      = 3'b000,
        PKT_CHE     = 3'b001,
        PKT_INV     = 3'b010,
        PKT_MR      = 3'b011,
        PKT_CHT     = 3'b100,
        PKT_DATA    = 3'b101,
        PKT_SOS     = 3'b110,
        PKT_INVALID = 3'b111
    } pkt_type_e;

    typedef enum logic [1:0] {
        VERDICT_DELIVER   = 2'd0,
        VERDICT_DROP      = 2'd1,
        VERDICT_MALFORMED = 2'd2
    } verdict_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/packet_unpacker_dest_check.sv
// Combinational packet classification: broadcast-class types always pass,
// unicast-class types pass only when addressed to us or to broadcast.
module packet_dest_check
    import packet_unpacker_pkg::*;
(
    input  logic [2:0]            pkt_type,
    input  logic [WORD_WIDTH-1:0] dest_id,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    output verdict_e              verdict,
    output logic                  i_am_dest
);

    pkt_type_e type_e;
    logic      addressed;

    assign type_e    = pkt_type_e'(pkt_type);
    assign i_am_dest = (dest_id == my_node_id);
    assign addressed = i_am_dest || (dest_id == BCAST_ID);

    always_comb begin
        verdict = VERDICT_MALFORMED;
        case (type_e)
            PKT_HB, PKT_CHE, PKT_INV:
                verdict = VERDICT_DELIVER;
            PKT_MR, PKT_CHT, PKT_DATA, PKT_SOS:
                verdict = addressed ? VERDICT_DELIVER : VERDICT_DROP;
            default:
                verdict = VERDICT_MALFORMED;
        endcase
    end

endmodule

// File: rtl/packet_unpacker.sv
// Receive-side packet unpacker: latches a fixed-length word stream into fields,
// classifies it and holds one delivered packet until the consumer acknowledges.
module packet_unpacker
    import packet_unpacker_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] rxData,
    input  logic                  rxValid,
    input  logic                  rxLast,
    output logic                  rxReady,
    input  logic                  fAck,
    output logic                  fValid,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fDestinationID,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic [WORD_WIDTH-1:0] fSourceHops,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic                  iAmDestination,
    output logic                  rxError,
    output logic [7:0]            dropCount
);

    state_e                state_reg, state_next;
    logic [2:0]            word_cnt_reg, word_cnt_next;
    logic [2:0]            type_reg;
    logic [WORD_WIDTH-1:0] field_reg [W_SOURCE:PKT_WORDS-1];
    logic [PKT_WORDS-1:1]  field_we;
    logic                  i_am_dest_reg;
    logic                  rx_error_reg, rx_error_next;
    logic [7:0]            drop_cnt_reg;
    logic                  drop_evt;
    logic                  deliver_evt;
    logic                  accept;
    logic                  load_field;
    verdict_e              verdict;
    logic                  chk_i_am_dest;

    // The destination word is already latched by the time word 7 arrives.
    packet_dest_check u_dest_check (
        .pkt_type   (type_reg),
        .dest_id    (field_reg[W_DESTINATION]),
        .my_node_id (myNodeID),
        .verdict    (verdict),
        .i_am_dest  (chk_i_am_dest)
    );

    assign accept     = rxValid && rxReady;
    assign load_field = accept && (state_reg == S_RECV);

    genvar gi;
    generate
        for (gi = W_SOURCE; gi < PKT_WORDS; gi++) begin : g_field_we
            assign field_we[gi] = load_field && (word_cnt_reg == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= S_IDLE;
            word_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_cnt_next = word_cnt_reg;
        rx_error_next = 1'b0;
        drop_evt      = 1'b0;
        deliver_evt   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    word_cnt_next = 3'd1;
                    if (rxLast) rx_error_next = 1'b1;
                    else        state_next    = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    word_cnt_next = word_cnt_reg + 3'd1;
                    if (word_cnt_reg == 3'(W_HOPS_CH)) begin
                        if (!rxLast) begin
                            state_next = S_DRAIN;
                        end else begin
                            state_next = S_IDLE;
                            case (verdict)
                                VERDICT_DELIVER: begin
                                    state_next  = S_HOLD;
                                    deliver_evt = 1'b1;
                                end
                                VERDICT_DROP:    drop_evt      = 1'b1;
                                default:         rx_error_next = 1'b1;
                            endcase
                        end
                    end else if (rxLast) begin
                        rx_error_next = 1'b1;
                        state_next    = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && rxLast) begin
                    rx_error_next = 1'b1;
                    state_next    = S_IDLE;
                end
            end
            S_HOLD: begin
                if (fAck) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // rxReady is forced low while reset is asserted, independent of en.
    always_comb begin
        rxReady = 1'b0;
        fValid  = 1'b0;
        case (state_reg)
            S_IDLE:          rxReady = en && nrst;
            S_RECV, S_DRAIN: rxReady = 1'b1;
            S_HOLD:          fValid  = 1'b1;
            default:         rxReady = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            type_reg      <= PKT_INVALID;
            i_am_dest_reg <= 1'b0;
            rx_error_reg  <= 1'b0;
            drop_cnt_reg  <= 8'd0;
            for (int i = W_SOURCE; i < PKT_WORDS; i++) field_reg[i] <= '0;
        end else begin
            rx_error_reg <= rx_error_next;
            if (accept && (state_reg == S_IDLE)) type_reg <= rxData[2:0];
            for (int i = W_SOURCE; i < PKT_WORDS; i++) begin
                if (field_we[i]) field_reg[i] <= rxData;
            end
            if (deliver_evt) i_am_dest_reg <= chk_i_am_dest;
            if (drop_evt && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign fPacketType    = type_reg;
    assign fSourceID      = field_reg[W_SOURCE];
    assign fDestinationID = field_reg[W_DESTINATION];
    assign fEnergyLeft    = field_reg[W_ENERGY];
    assign fQValue        = field_reg[W_QVALUE];
    assign fSourceHops    = field_reg[W_SRC_HOPS];
    assign fChosenCH      = field_reg[W_CHOSEN_CH];
    assign fHopsFromCH    = field_reg[W_HOPS_CH];
    assign iAmDestination = i_am_dest_reg;
    assign rxError        = rx_error_reg;
    assign dropCount      = drop_cnt_reg;

endmodule

// File: tb/tb_packet_unpacker.sv
// Directed bench for packet_unpacker: expected packets are queued when sent and
// compared when fValid appears; drop count and error pulses use a small model.
module tb_packet_unpacker;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [15:0] myNodeID;
    logic [15:0] rxData;
    logic        rxValid;
    logic        rxLast;
    logic        rxReady;
    logic        fAck;
    logic        fValid;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID, fDestinationID, fEnergyLeft, fQValue;
    logic [15:0] fSourceHops, fChosenCH, fHopsFromCH;
    logic        iAmDestination;
    logic        rxError;
    logic [7:0]  dropCount;

    packet_unpacker dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .myNodeID       (myNodeID),
        .rxData         (rxData),
        .rxValid        (rxValid),
        .rxLast         (rxLast),
        .rxReady        (rxReady),
        .fAck           (fAck),
        .fValid         (fValid),
        .fPacketType    (fPacketType),
        .fSourceID      (fSourceID),
        .fDestinationID (fDestinationID),
        .fEnergyLeft    (fEnergyLeft),
        .fQValue        (fQValue),
        .fSourceHops    (fSourceHops),
        .fChosenCH      (fChosenCH),
        .fHopsFromCH    (fHopsFromCH),
        .iAmDestination (iAmDestination),
        .rxError        (rxError),
        .dropCount      (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       t;
        logic [6:0][15:0] f;
        logic             iam;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] pkt_w [0:15];
    int          checks = 0;
    int          errors = 0;
    int          drop_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_deliver(input logic [2:0] t, input logic [15:0] d, input logic [15:0] me);
        if (t == 3'b111) return 1'b0;
        if (t <= 3'b010) return 1'b1;
        return (d == me) || (d == 16'hFFFF);
    endfunction

    task automatic build(input logic [2:0] t, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] base);
        pkt_w[0] = {13'h1ABC, t};
        pkt_w[1] = src;
        pkt_w[2] = dst;
        for (int i = 3; i < 16; i++) pkt_w[i] = base + 16'(i);
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send_word(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        rxData  = d;
        rxValid = 1'b1;
        rxLast  = last;
        while (!rxReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rxReady_wait", {31'd0, rxReady}, 32'd1);
        @(negedge clk);
        rxValid = 1'b0;
        rxLast  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit last);
        for (int i = 0; i < n; i++) send_word(pkt_w[i], last && (i == n - 1));
    endtask

    task automatic send_and_check(input int n);
        logic [2:0] t;
        bit         full, del, exp_err;
        exp_t       e;
        t    = pkt_w[0][2:0];
        full = (n == 8);
        del  = full && exp_deliver(t, pkt_w[2], myNodeID);
        if (del) begin
            e.t   = t;
            for (int k = 0; k < 7; k++) e.f[k] = pkt_w[k + 1];
            e.iam = (pkt_w[2] == myNodeID);
            sb.push_back(e);
        end
        if (full && t >= 3'd3 && t <= 3'd6 && !del && drop_model < 255) drop_model++;
        exp_err = !full || (t == 3'b111);
        send_pkt(n, 1'b1);
        chk("rxError", {31'd0, rxError}, {31'd0, exp_err});
        chk("dropCount", {24'd0, dropCount}, 32'(drop_model));
        if (sb.size() > 0) begin
            chk("fValid_deliver", {31'd0, fValid}, 32'd1);
            e = sb.pop_front();
            chk("fPacketType", {29'd0, fPacketType}, {29'd0, e.t});
            chk("fSourceID", {16'd0, fSourceID}, {16'd0, e.f[0]});
            chk("fDestinationID", {16'd0, fDestinationID}, {16'd0, e.f[1]});
            chk("fEnergyLeft", {16'd0, fEnergyLeft}, {16'd0, e.f[2]});
            chk("fQValue", {16'd0, fQValue}, {16'd0, e.f[3]});
            chk("fSourceHops", {16'd0, fSourceHops}, {16'd0, e.f[4]});
            chk("fChosenCH", {16'd0, fChosenCH}, {16'd0, e.f[5]});
            chk("fHopsFromCH", {16'd0, fHopsFromCH}, {16'd0, e.f[6]});
            chk("iAmDestination", {31'd0, iAmDestination}, {31'd0, e.iam});
        end else begin
            chk("fValid_none", {31'd0, fValid}, 32'd0);
        end
    endtask

    task automatic ack();
        fAck = 1'b1;
        @(negedge clk);
        fAck = 1'b0;
        chk("fValid_after_ack", {31'd0, fValid}, 32'd0);
        chk("rxReady_after_ack", {31'd0, rxReady}, {31'd0, en});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_fValid"}, {31'd0, fValid}, 32'd0);
        chk({tag, "_rxReady"}, {31'd0, rxReady}, 32'd0);
        chk({tag, "_fPacketType"}, {29'd0, fPacketType}, 32'd7);
        chk({tag, "_fSourceID"}, {16'd0, fSourceID}, 32'd0);
        chk({tag, "_fHopsFromCH"}, {16'd0, fHopsFromCH}, 32'd0);
        chk({tag, "_iAmDestination"}, {31'd0, iAmDestination}, 32'd0);
        chk({tag, "_rxError"}, {31'd0, rxError}, 32'd0);
        chk({tag, "_dropCount"}, {24'd0, dropCount}, 32'd0);
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; myNodeID = 16'h0003;
        rxData = '0; rxValid = 1'b0; rxLast = 1'b0; fAck = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        nrst = 1'b1;
        @(negedge clk);

        // en low blocks a new packet
        en = 1'b0;
        #1 chk("rxReady_en_low", {31'd0, rxReady}, 32'd0);
        en = 1'b1;
        #1 chk("rxReady_en_high", {31'd0, rxReady}, 32'd1);
        @(negedge clk);

        // HB broadcast, held until fAck
        build(3'b000, 16'h0007, 16'hFFFF, 16'h0010);
        send_and_check(8);
        repeat (3) begin
            @(negedge clk);
            chk("hold_fValid", {31'd0, fValid}, 32'd1);
            chk("hold_rxReady", {31'd0, rxReady}, 32'd0);
            chk("hold_fSourceID", {16'd0, fSourceID}, 32'h0007);
        end
        ack();

        // Data unicast to us
        build(3'b101, 16'h0042, 16'h0003, 16'h0200);
        send_and_check(8);
        ack();

        // Data unicast elsewhere: dropped
        build(3'b101, 16'h0042, 16'h0009, 16'h0300);
        send_and_check(8);
        chk("dropCount_one", {24'd0, dropCount}, 32'd1);

        // Saturation of the drop counter
        for (int i = 0; i < 299; i++) begin
            build(3'b011 + 3'(i % 4), 16'(i), 16'h0009, 16'(i * 3));
            send_and_check(8);
        end
        chk("dropCount_sat", {24'd0, dropCount}, 32'd255);

        // Short packet: rxLast on word 4
        build(3'b000, 16'h0101, 16'hFFFF, 16'h0400);
        send_and_check(5);
        @(negedge clk);
        chk("rxError_pulse_end", {31'd0, rxError}, 32'd0);
        build(3'b011, 16'h0055, 16'h0003, 16'h0500);
        send_and_check(8);
        ack();

        // Overlong packet drained
        build(3'b001, 16'h0066, 16'hFFFF, 16'h0600);
        send_and_check(10);

        // Malformed type
        build(3'b111, 16'h0077, 16'h0003, 16'h0700);
        send_and_check(8);

        // Packet arriving during hold waits for fAck
        build(3'b110, 16'h0088, 16'hFFFF, 16'h0800);
        send_and_check(8);
        build(3'b100, 16'h0099, 16'h0003, 16'h0900);
        rxData = pkt_w[0]; rxValid = 1'b1; rxLast = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("busy_rxReady", {31'd0, rxReady}, 32'd0);
            chk("busy_fValid", {31'd0, fValid}, 32'd1);
        end
        ack();
        send_and_check(8);
        ack();

        // Reset after word 3
        build(3'b000, 16'h00AA, 16'hFFFF, 16'h0A00);
        send_pkt(4, 1'b0);
        nrst = 1'b0;
        #2;
        check_reset_state("midreset");
        drop_model = 0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        build(3'b010, 16'h0011, 16'h0022, 16'h0100);
        send_and_check(8);
        chk("inv_hops_from_ch", {16'd0, fHopsFromCH}, 32'h0107);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_unpacker.md
# packet_unpacker

Receive-side counterpart of the reward packer: accepts an incoming packet as a fixed-length stream of 16-bit words from the radio/MAC interface, latches every field, classifies the packet type, and determines whether this node is the addressed destination. Holds one decoded packet until the downstream node-logic (packet filter, MY_NODE_INFO, neighborTable, reward) acknowledges it. Drops unicast packets addressed elsewhere, and flags malformed packets.

## Interface
- WORD_WIDTH, 16, width of every packet word and field
- PKT_WORDS, 8, words per packet (fixed; header + 7 fields)
- BCAST_ID, 16'hFFFF, broadcast destination ID
- clk  in  1  clock
- nrst  in  1  reset; asynchronous, active-low
- en  in  1  receiver enable; gates acceptance of a new packet only
- myNodeID  in  WORD_WIDTH  this node's ID
- rxData  in  WORD_WIDTH  incoming word
- rxValid  in  1  rxData valid
- rxLast  in  1  marks final word of a packet
- rxReady  out  1  word accepted when rxValid && rxReady
- fAck  in  1  consumer has taken the held packet
- fValid  out  1  decoded packet available
- fPacketType  out  3  header[2:0]
- fSourceID, fDestinationID, fEnergyLeft, fQValue, fSourceHops, fChosenCH, fHopsFromCH  out  WORD_WIDTH each  latched fields
- iAmDestination  out  1  fDestinationID == myNodeID
- rxError  out  1  one-cycle pulse: malformed packet
- dropCount  out  8  saturating count of packets dropped as not-for-me

## Operation
- Word order: 0 header (type in [2:0], [15:3] ignored), 1 sourceID, 2 destinationID, 3 energyLeft, 4 QValue, 5 sourceHops, 6 chosenCH, 7 hopsFromCH.
- Types: HB 000, CHE 001, INV 010 broadcast-class, always delivered. MR 011, CHT 100, Data 101, SOS 110 unicast-class, delivered only if destination == myNodeID or == BCAST_ID; otherwise dropped, dropCount += 1 (saturates at 255). Type 111 is malformed.
- States: S_IDLE, S_RECV, S_HOLD, S_DRAIN.
- S_IDLE: rxReady = en. Accepted word = header, wordCnt <= 1, go S_RECV. If that word has rxLast: rxError pulse, stay S_IDLE.
- S_RECV: rxReady = 1 (en ignored mid-packet). Each accepted word written to field selected by wordCnt; wordCnt 3-bit increment.
  - rxLast with wordCnt < 7: rxError, S_IDLE, fields partially overwritten (don't-care, fValid stays 0).
  - wordCnt == 7, rxLast: evaluate type/destination (word 2 already latched); deliver -> S_HOLD; drop -> S_IDLE; type 111 -> rxError, S_IDLE.
  - wordCnt == 7, no rxLast: go S_DRAIN.
- S_DRAIN: rxReady = 1, discard words until rxLast accepted, then rxError, S_IDLE.
- S_HOLD: fValid = 1, rxReady = 0, fields stable. fAck -> S_IDLE next cycle. fAck in any other state ignored.
- iAmDestination registered with the field set, valid whenever fValid.

## Timing
- Reset: state S_IDLE, all f* fields 0, fPacketType 3'b111, fValid 0, iAmDestination 0, rxError 0, dropCount 0, wordCnt 0; rxReady 0 while nrst low.
- Minimum packet: 8 cycles of accepted words; fValid high the cycle after the final word is accepted.
- fValid and fAck same cycle: fValid low next cycle; rxReady rises that same next cycle (if en), so back-to-back packets lose one cycle per packet.
- rxError is a single-cycle pulse the cycle after the offending rxLast word is accepted.
- rxValid gaps mid-packet: state/wordCnt hold; no timeout.
- Reset mid-packet: partial packet discarded, all outputs to reset values.

## Structure
- Shared package: packet-type enum (HB..SOS, INVALID=3'b111), word-index localparams, BCAST_ID, state enum.
- One natural sub-module: packet_dest_check (combinational type-class + destination match returning deliver/drop/malformed), reused by the filter logic.

## Test plan
- HB from source 0x0007, dest 0xFFFF, myNodeID 0x0003 -> fValid one cycle after word 7, fPacketType 000, fSourceID 0x0007, iAmDestination 0; held until fAck.
- Data, dest 0x0003, myNodeID 0x0003 -> delivered, iAmDestination 1; same with dest 0x0009 -> no fValid, dropCount 1; 300 such -> dropCount 255.
- rxLast on word 4 -> rxError pulse, fValid 0, next good packet decoded correctly.
- 10-word packet (rxLast on word 9) -> S_DRAIN, rxError after word 9, no fValid.
- Header type 111 with 8 words -> rxError, no fValid; packet arriving during S_HOLD sees rxReady 0 until fAck.
- nrst asserted after word 3 -> all outputs reset values, next full INV packet delivered with fHopsFromCH = word 7 value.
